background_fifo: RTL and testbench

Background pixel FIFO sitting at the consumer end of the background fetcher's push interface. It accepts 8-pixel tile rows from the fetcher, reports emptiness back to it, discards the first `SCX mod 8` pixels of each scanline for fine scroll, and shifts out one 2-bit colour index per T-cycle to the pixel mixer/LCD stage. It also maintains the scanline X position during mode 3.

---
 rtl/background_fifo.sv | 118 +++++++++++
 tb/tb_background_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/background_fifo.sv
// Background pixel FIFO between the tile fetcher and the pixel mixer.
// Applies fine-scroll discard, emits one colour index per T-cycle and tracks scanline X.
module background_fifo #(
  parameter int X_MAX = 160,
  parameter int DEPTH = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         tclk_in,
  input  logic                         line_start_in,
  input  logic                         window_start_in,
  input  logic [7:0]                   SCX_in,
  input  logic                         stall_in,
  input  logic                         valid_pixels_in,
  input  logic [7:0][1:0]              pixels_in,
  output logic                         bg_fifo_empty_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic [1:0]                   pixel_out,
  output logic                         pixel_valid_out,
  output logic [$clog2(X_MAX)-1:0]     X_out,
  output logic                         line_done_out,
  output logic                         overflow_out
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = $clog2(X_MAX);
  localparam logic [CW-1:0] PUSH_MAX = CW'(DEPTH - 8);
  localparam logic [XW-1:0] X_LAST   = XW'(X_MAX - 1);

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    discard;
  logic          pop;
  logic          push_ok;
  logic          push_drop;

  logic unused_scx;
  assign unused_scx = ^SCX_in[7:3];

  // Circular index; base + offset never exceeds 2*DEPTH so one subtraction suffices.
  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input logic [CW-1:0] off);
    logic [CW+1:0] s;
    s = (CW+2)'(base) + (CW+2)'(off);
    if (s >= (CW+2)'(DEPTH))
      s = s - (CW+2)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    pop       = 1'b0;
    push_ok   = 1'b0;
    push_drop = 1'b0;
    if (tclk_in && !line_start_in && !window_start_in) begin
      pop       = (count != '0) && !stall_in && !line_done_out;
      push_ok   = valid_pixels_in && (count <= PUSH_MAX);
      push_drop = valid_pixels_in && (count >  PUSH_MAX);
    end
  end

  // New row lands behind the pre-pop tail, so a same-cycle pop cannot disturb it.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      for (int i = 0; i < 8; i++)
        mem[slot(rd_ptr, count + CW'(i))] <= pixels_in[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr          <= '0;
      count           <= '0;
      discard         <= '0;
      X_out           <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      line_done_out   <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      pixel_valid_out <= 1'b0;
      if (tclk_in) begin
        if (line_start_in) begin
          rd_ptr        <= '0;
          count         <= '0;
          discard       <= SCX_in[2:0];
          X_out         <= '0;
          line_done_out <= 1'b0;
          overflow_out  <= 1'b0;
        end else if (window_start_in) begin
          rd_ptr  <= '0;
          count   <= '0;
          discard <= '0;
        end else begin
          count <= count - CW'(pop) + (push_ok ? CW'(8) : CW'(0));
          if (push_drop)
            overflow_out <= 1'b1;
          if (pop) begin
            rd_ptr <= slot(rd_ptr, CW'(1));
            if (discard != 3'd0) begin
              discard <= discard - 3'd1;
            end else begin
              pixel_out       <= mem[rd_ptr];
              pixel_valid_out <= 1'b1;
              if (X_out == X_LAST)
                line_done_out <= 1'b1;
              else
                X_out <= X_out + XW'(1);
            end
          end
        end
      end
    end
  end

  assign count_out         = count;
  assign bg_fifo_empty_out = (count == '0);

endmodule

// File: tb/tb_background_fifo.sv
// Self-checking bench for background_fifo: a queue-based reference model,
// a fine-scroll vector table, directed corner sequences and a random soak.
module tb_background_fifo;
  localparam int X_MAX = 160;
  localparam int DEPTH = 16;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             tclk_in;
  logic             line_start_in;
  logic             window_start_in;
  logic [7:0]       SCX_in;
  logic             stall_in;
  logic             valid_pixels_in;
  logic [7:0][1:0]  pixels_in;
  logic             bg_fifo_empty_out;
  logic [4:0]       count_out;
  logic [1:0]       pixel_out;
  logic             pixel_valid_out;
  logic [7:0]       X_out;
  logic             line_done_out;
  logic             overflow_out;

  background_fifo #(.X_MAX(X_MAX), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tclk_in(tclk_in),
    .line_start_in(line_start_in), .window_start_in(window_start_in),
    .SCX_in(SCX_in), .stall_in(stall_in), .valid_pixels_in(valid_pixels_in),
    .pixels_in(pixels_in), .bg_fifo_empty_out(bg_fifo_empty_out),
    .count_out(count_out), .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out),
    .X_out(X_out), .line_done_out(line_done_out), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int q[$];
  int m_disc, m_x, m_pix;
  bit m_pv, m_done, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_disc = 0; m_x = 0; m_pix = 0; m_pv = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    int pre;
    int head;
    bit do_pop;
    m_pv = 0;
    if (!tclk_in) return;
    if (line_start_in) begin
      q.delete(); m_disc = int'(SCX_in % 8); m_x = 0; m_done = 0; m_ovf = 0;
    end else if (window_start_in) begin
      q.delete(); m_disc = 0;
    end else begin
      pre    = q.size();
      do_pop = (pre > 0) && !stall_in && !m_done;
      head   = 0;
      if (do_pop) head = q.pop_front();
      if (valid_pixels_in) begin
        if (pre <= DEPTH - 8) for (int i = 0; i < 8; i++) q.push_back(int'(pixels_in[i]));
        else m_ovf = 1;
      end
      if (do_pop) begin
        if (m_disc > 0) m_disc--;
        else begin
          m_pix = head; m_pv = 1;
          if (m_x == X_MAX - 1) m_done = 1; else m_x++;
        end
      end
    end
  endtask

  task automatic check_all();
    check("count", int'(count_out), q.size());
    check("empty", int'(bg_fifo_empty_out), int'(q.size() == 0));
    check("pixel_valid", int'(pixel_valid_out), int'(m_pv));
    check("pixel", int'(pixel_out), m_pix);
    check("x", int'(X_out), m_x);
    check("line_done", int'(line_done_out), int'(m_done));
    check("overflow", int'(overflow_out), int'(m_ovf));
  endtask

  task automatic apply(input bit a_ls, input bit a_ws, input logic [7:0] a_scx, input bit a_stall,
                       input bit a_vpi, input logic [7:0][1:0] a_pix, input bit a_tclk);
    line_start_in   = a_ls;
    window_start_in = a_ws;
    SCX_in          = a_scx;
    stall_in        = a_stall;
    valid_pixels_in = a_vpi;
    pixels_in       = a_pix;
    tclk_in         = a_tclk;
    @(posedge clk_in);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [7:0][1:0] row8(input int a, b, c, d, e, f, g, h);
    logic [7:0][1:0] r;
    r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(d);
    r[4] = 2'(e); r[5] = 2'(f); r[6] = 2'(g); r[7] = 2'(h);
    return r;
  endfunction

  logic [7:0][1:0] plain_row;

  // Push a row whenever the FIFO is empty until X reaches tx with nothing stored.
  task automatic run_to(input int tx);
    int n;
    n = 0;
    while (!(int'(X_out) == tx && count_out == 0) && n < 400) begin
      apply(0, 0, 8'd0, 0, count_out == 0, plain_row, 1);
      n++;
    end
    check("run_to_bound", int'(n < 400), 1);
  endtask

  typedef struct {
    bit              ls;
    logic [7:0]      scx;
    bit              vpi;
    logic [7:0][1:0] pix;
    bit              ex_pv;
    int              ex_pix;
    int              ex_x;
    int              ex_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [7:0][1:0] r;
    int n_emit, n;

    plain_row = row8(0, 1, 2, 3, 0, 1, 2, 3);
    r = row8(3, 3, 3, 3, 3, 2, 1, 0);
    tbl[0]  = '{1, 8'h05, 0, r, 0, 0, 0, 0};
    tbl[1]  = '{0, 8'h05, 1, r, 0, 0, 0, 8};
    tbl[2]  = '{0, 8'h05, 0, r, 0, 0, 0, 7};
    tbl[3]  = '{0, 8'h05, 0, r, 0, 0, 0, 6};
    tbl[4]  = '{0, 8'h05, 0, r, 0, 0, 0, 5};
    tbl[5]  = '{0, 8'h05, 0, r, 0, 0, 0, 4};
    tbl[6]  = '{0, 8'h05, 0, r, 0, 0, 0, 3};
    tbl[7]  = '{0, 8'h05, 0, r, 1, 2, 1, 2};
    tbl[8]  = '{0, 8'h05, 0, r, 1, 1, 2, 1};
    tbl[9]  = '{0, 8'h05, 0, r, 1, 0, 3, 0};
    tbl[10] = '{0, 8'h05, 0, r, 0, 0, 3, 0};

    rst_n_in = 0; tclk_in = 0; line_start_in = 0; window_start_in = 0;
    SCX_in = 0; stall_in = 0; valid_pixels_in = 0; pixels_in = '0;
    model_reset();
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_n_in = 1;
    check_all();

    // Fine scroll
    foreach (tbl[i]) begin
      apply(tbl[i].ls, 0, tbl[i].scx, 0, tbl[i].vpi, tbl[i].pix, 1);
      check("tbl_pv", int'(pixel_valid_out), int'(tbl[i].ex_pv));
      if (tbl[i].ex_pv) check("tbl_pix", int'(pixel_out), tbl[i].ex_pix);
      check("tbl_x", int'(X_out), tbl[i].ex_x);
      check("tbl_count", int'(count_out), tbl[i].ex_cnt);
    end

    // Plain line
    apply(1, 0, 8'd0, 0, 0, plain_row, 1);
    n_emit = 0; n = 0;
    while (!line_done_out && n < 400) begin
      apply(0, 0, 8'd0, 0, count_out == 0, plain_row, 1);
      if (pixel_valid_out) begin
        check("plain_pix", int'(pixel_out), n_emit % 4);
        n_emit++;
      end
      n++;
    end
    check("plain_done", int'(line_done_out), 1);
    check("plain_emits", n_emit, X_MAX);
    check("plain_x", int'(X_out), X_MAX - 1);
    n_emit = 0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 8'd0, 0, (i % 3) == 0, plain_row, 1);
      if (pixel_valid_out) n_emit++;
    end
    check("done_no_pop", n_emit, 0);

    // Stall at count 5
    r = row8(1, 2, 3, 0, 2, 1, 0, 3);
    apply(1, 0, 8'd0, 0, 0, r, 1);
    apply(0, 0, 8'd0, 0, 1, r, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 8'd0, 0, 0, r, 1);
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 8'd0, 1, 0, r, 1);
      check("stall_count", int'(count_out), 5);
      check("stall_x", int'(X_out), 3);
      check("stall_pv", int'(pixel_valid_out), 0);
    end
    apply(0, 0, 8'd0, 0, 0, r, 1);
    check("unstall_pv", int'(pixel_valid_out), 1);
    check("unstall_pix", int'(pixel_out), 0);
    check("unstall_x", int'(X_out), 4);

    // Boundary: push+pop at 8, refused push at 9
    apply(1, 0, 8'd0, 0, 0, r, 1);
    apply(0, 0, 8'd0, 0, 1, row8(0, 1, 2, 3, 3, 2, 1, 0), 1);
    apply(0, 0, 8'd0, 0, 1, row8(2, 2, 1, 1, 3, 3, 0, 0), 1);
    check("bnd_count15", int'(count_out), 15);
    for (int i = 0; i < 6; i++) apply(0, 0, 8'd0, 0, 0, r, 1);
    check("bnd_count9", int'(count_out), 9);
    apply(0, 0, 8'd0, 0, 1, row8(1, 1, 1, 1, 1, 1, 1, 1), 1);
    check("bnd_drop_count", int'(count_out), 8);
    check("bnd_overflow", int'(overflow_out), 1);
    for (int i = 0; i < 12; i++) apply(0, 0, 8'd0, 0, 0, r, 1);

    // Window flush at count 6, X 50
    apply(1, 0, 8'd0, 0, 0, r, 1);
    run_to(48);
    apply(0, 0, 8'd0, 0, 1, plain_row, 1);
    apply(0, 0, 8'd0, 0, 0, plain_row, 1);
    apply(0, 0, 8'd0, 0, 0, plain_row, 1);
    check("win_pre_count", int'(count_out), 6);
    check("win_pre_x", int'(X_out), 50);
    apply(0, 1, 8'd0, 0, 0, plain_row, 1);
    check("win_count", int'(count_out), 0);
    check("win_empty", int'(bg_fifo_empty_out), 1);
    check("win_x", int'(X_out), 50);
    apply(0, 0, 8'd0, 0, 1, row8(3, 1, 2, 0, 0, 0, 0, 0), 1);
    apply(0, 0, 8'd0, 0, 0, plain_row, 1);
    check("win_emit_pv", int'(pixel_valid_out), 1);
    check("win_emit_pix", int'(pixel_out), 3);
    check("win_emit_x", int'(X_out), 51);

    // Async reset mid-line at count 12, X 40
    apply(1, 0, 8'd0, 0, 0, plain_row, 1);
    run_to(32);
    apply(0, 0, 8'd0, 0, 1, plain_row, 1);
    for (int i = 0; i < 4; i++) apply(0, 0, 8'd0, 0, 0, plain_row, 1);
    apply(0, 1, 8'd0, 0, 0, plain_row, 1);
    apply(0, 0, 8'd0, 0, 1, plain_row, 1);
    for (int i = 0; i < 4; i++) apply(0, 0, 8'd0, 0, 0, plain_row, 1);
    apply(0, 0, 8'd0, 1, 1, plain_row, 1);
    apply(1, 0, 8'd0, 1, 0, plain_row, 0);
    check("rst_pre_count", int'(count_out), 12);
    check("rst_pre_x", int'(X_out), 40);
    #3;
    rst_n_in = 0;
    #1;
    check("rst_count", int'(count_out), 0);
    check("rst_empty", int'(bg_fifo_empty_out), 1);
    check("rst_x", int'(X_out), 0);
    check("rst_pix", int'(pixel_out), 0);
    check("rst_pv", int'(pixel_valid_out), 0);
    check("rst_done", int'(line_done_out), 0);
    check("rst_ovf", int'(overflow_out), 0);
    model_reset();
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_n_in = 1;
    check_all();

    // Random soak
    apply(1, 0, 8'($urandom), 0, 0, plain_row, 1);
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, 8'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
